// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and ALU opcode encoding.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 16;
  typedef enum logic [OP_W-1:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_ADD = 4'b0011,
    OP_SUB = 4'b0100,
    OP_MUL = 4'b0101,
    OP_DIV = 4'b0110,
    OP_REM = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_ROL = 4'b1010,
    OP_ROR = 4'b1011
  } alu_op_e;
endpackage

// File: rtl/reg_file.sv
// reg_file: 2 async read ports, 1 sync write port, r0 hardwired to zero.
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int AW     = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1_i,
  input  logic [AW-1:0]     ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i
);
  localparam int NREG = 1 << AW;
  logic [DATA_W-1:0] mem_q [NREG];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      mem_q[wa_i] <= wd_i;
    end
  end
  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads ALU operands with writeback bypass, stalls on scoreboard
// hazards, and holds them in a registered valid/ready output stage.
module operand_fetch #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int OP_W   = cpu_pkg::OP_W,
  parameter int IMM_W  = cpu_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_imm,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_opcode,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
);
  import cpu_pkg::*;
  localparam int NREG = 1 << REG_AW;
  logic [DATA_W-1:0] rf_a, rf_b, a_d, b_d, imm_ext, out_a_q, out_b_q;
  logic [OP_W-1:0]   out_opcode_q;
  logic [REG_AW-1:0] out_rd_q;
  logic              out_valid_q, out_valid_d, hazard, accept, wb_we;
  logic [NREG-1:0]   pend_q, pend_d, wb_clr, pend_eff, acc_set;
  assign wb_we = wb_en && wb_rd != '0;
  reg_file #(.DATA_W(DATA_W), .AW(REG_AW)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (in_rs1),
    .ra2_i (in_rs2),
    .rd1_o (rf_a),
    .rd2_o (rf_b),
    .we_i  (wb_we),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );
  // A writeback retiring this cycle already satisfies any hazard on its register.
  always_comb begin
    wb_clr      = wb_we ? NREG'(1) << wb_rd : '0;
    pend_eff    = pend_q & ~wb_clr;
    hazard      = pend_eff[in_rs1] | (!in_use_imm & pend_eff[in_rs2]) | ((in_rd != '0) & pend_eff[in_rd]);
    in_ready    = !hazard && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    imm_ext     = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    a_d         = (wb_we && wb_rd == in_rs1) ? wb_data : rf_a;
    b_d         = in_use_imm ? imm_ext : (wb_we && wb_rd == in_rs2) ? wb_data : rf_b;
    acc_set     = (accept && in_rd != '0) ? NREG'(1) << in_rd : '0;
    pend_d      = (pend_q & ~wb_clr) | acc_set;
    out_valid_d = accept | (out_valid_q & !out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_opcode_q <= OP_W'(OP_AND);
      out_rd_q     <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_a_q      <= a_d;
        out_b_q      <= b_d;
        out_opcode_q <= in_opcode;
        out_rd_q     <= in_rd;
      end
    end
  end
  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_opcode = out_opcode_q;
  assign out_rd     = out_rd_q;
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of the ALU: accepts decoded instruction fields, reads two operands from a 32×32 register file, and presents `A`, `B` and `opcode` to the ALU through a registered valid/ready output. A one-bit-per-register scoreboard stalls instructions whose sources or destination have an outstanding write. A same-cycle writeback bypass lets the ALU's retired results feed the next instruction without an extra bubble.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width
- `REG_AW`, 5, register address width (2^REG_AW registers)
- `OP_W`, 4, ALU opcode width
- `IMM_W`, 16, immediate width, sign-extended to DATA_W

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction fields valid
- `in_ready`  out  1  stage accepts instruction this cycle
- `in_opcode`  in  OP_W  ALU operation
- `in_rs1`, `in_rs2`  in  REG_AW  source registers
- `in_rd`  in  REG_AW  destination register (0 = no write)
- `in_use_imm`  in  1  B operand = sign-extended `in_imm`; `in_rs2` ignored
- `in_imm`  in  IMM_W  immediate
- `out_valid`  out  1  operands valid to ALU
- `out_ready`  in  1  ALU consumes this cycle
- `out_a`, `out_b`  out  DATA_W  ALU operands
- `out_opcode`  out  OP_W  ALU opcode
- `out_rd`  out  REG_AW  destination carried to writeback
- `wb_en`  in  1  writeback strobe
- `wb_rd`  in  REG_AW  writeback register
- `wb_data`  in  DATA_W  writeback value

## Operation
- Register 0 reads as 0. Writes to register 0 are dropped and never mark it pending.
- Effective source value: if `wb_en && wb_rd == rs && rs != 0`, the value is `wb_data` (bypass). Otherwise it is the register-file contents.
- Effective pending bit: `pend[r] && !(wb_en && wb_rd == r)`.
- Hazard, asserted if any of:
  - rs1 is effectively pending.
  - `!in_use_imm` and rs2 is effectively pending.
  - `in_rd != 0` and in_rd is effectively pending (WAW).
- `in_ready = !hazard && (!out_valid || out_ready)`. This is combinational on the `in_*`, `wb_*` and `out_ready` inputs.
- Accept: `in_valid && in_ready`. On accept:
  - The output register loads the operands, opcode and rd.
  - `out_valid` is set.
  - `pend[in_rd]` is set if `in_rd != 0`.
- `out_valid` clears when `out_ready && !accept`.
- Writeback:
  - `wb_en && wb_rd != 0` writes the register file and clears `pend[wb_rd]`.
  - If an accept sets the same index in the same cycle, the set wins.
- B operand when `in_use_imm`: `{{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm}`.
- Output fields are held stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `out_a`, `out_b`, `out_rd` = 0; `out_opcode` = 0 (AND).
  - All registers = 0; all pending bits = 0.
- `in_ready` is not forced low during reset. Accepts in a reset cycle are discarded.
- Latency: accept in cycle N gives `out_valid` in cycle N+1.
- Throughput is 1 instruction/cycle when there is no hazard and `out_ready` is high.
- Register-file write takes effect at the clock edge. A read in the same cycle sees `wb_data` through the bypass, never a stale value.
- Dependent back-to-back instructions stall until writeback of the producer. Issue occurs in the same cycle `wb_en` presents the producer's rd.
- Reset mid-operation: the output register is invalidated next cycle and the scoreboard is cleared. Writebacks in flight after reset still update the register file but do not stall.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`, `REG_AW`, `OP_W`.
  - ALU opcode constants: `OP_AND`=4'b0000, `OP_OR`=4'b0001, `OP_XOR`=4'b0010, `OP_ADD`=4'b0011, and reserved codes 0100–1011 (SUB, MUL, DIV, REM, SHL, SHR, ROL, ROR).
- Sub-module `reg_file`:
  - 2 asynchronous read ports, 1 synchronous write port, r0 hardwired zero.
  - Bypass and scoreboard live in `operand_fetch`.

## Test plan
- Reset, then issue ADD rs1=0, rs2=0, rd=3 → next cycle `out_valid`=1, `out_a`=`out_b`=0, `out_opcode`=0011, `out_rd`=3, `pend[3]`=1.
- Preload r1=5 via writeback, issue rs1=1 with imm 16'hFFFF → `out_a`=5, `out_b`=32'hFFFF_FFFF.
- Issue rd=4, then dependent rs1=4 → `in_ready`=0. When `wb_en`, `wb_rd`=4, `wb_data`=0xA5, it is accepted that cycle with `out_a`=0xA5.
- Hold `out_ready`=0 for 3 cycles with valid output → outputs stable, `in_ready`=0. Release → next instruction accepted.
- Writeback to r0 with 0xDEAD, then read r0 → `out_a`=0. A WAW issue on pending rd=7 stalls until r7 is written back.
- Assert `rst` while `out_valid`=1 and `pend[3]`=1 → next cycle `out_valid`=0, scoreboard clear; issuing rs1=3 proceeds without stall.
